wb_regfile: RTL and testbench

Writeback stage and architectural register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline-register outputs (instruction, memory data, ALU result, destination register, PC) and decodes the writeback control from the instruction. It selects the write value and commits it to a 32×32 register file. It also serves the two ID-stage read ports, with same-cycle write-to-read bypass, and keeps a retired-instruction counter for debug and perf.

---
 rtl/wb_regfile.sv | 117 +++++++++++
 tb/tb_wb_regfile.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage of the 5-stage MIPS pipeline: decodes writeback control, selects the
// write value, commits it to the 32x32 register file, serves two bypassed read ports and
// tracks retired instructions.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_WB_instr,
  input  logic [31:0] DataMem_MEM_WB_r,
  input  logic [31:0] ALUOut_MEM_WB_r,
  input  logic [4:0]  WriteDst_MEM_WB_r,
  input  logic [29:0] MEM_WB_PC_r,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] retire_cnt,
  output logic [29:0] last_pc
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [31:0] regs_r [32];
  logic [31:0] retire_cnt_r;
  logic [29:0] last_pc_r;
  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic        bubble_s;
  logic [29:0] link_pc_s;

  function automatic logic writes_reg(input logic [5:0] op, input logic [5:0] funct);
    logic w;
    case (op)
      OP_RTYPE: w = (funct != FN_JR);
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: w = 1'b1;
      OP_LW:    w = 1'b1;
      OP_JAL:   w = 1'b1;
      default:  w = 1'b0;
    endcase
    return w;
  endfunction

  // $0 always reads zero; a write committing this cycle is visible before it lands.
  function automatic logic [31:0] read_sel(input logic [4:0] ra, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd,
                                           input logic [31:0] arr);
    logic [31:0] v;
    if (ra == 5'd0) begin
      v = 32'h0000_0000;
    end else if (we && (ra == wa)) begin
      v = wd;
    end else begin
      v = arr;
    end
    return v;
  endfunction

  assign op_s      = MEM_WB_instr[31:26];
  assign funct_s   = MEM_WB_instr[5:0];
  assign bubble_s  = (MEM_WB_instr == 32'h0000_0000);
  assign link_pc_s = MEM_WB_PC_r + 30'd1;
  assign wb_addr   = WriteDst_MEM_WB_r;

  // Writeback decode and data select
  always_comb begin
    wb_we   = 1'b0;
    wb_data = ALUOut_MEM_WB_r;
    if (rst && !bubble_s && (WriteDst_MEM_WB_r != 5'd0)) begin
      wb_we = writes_reg(op_s, funct_s);
    end else begin
      wb_we = 1'b0;
    end
    case (op_s)
      OP_LW:   wb_data = DataMem_MEM_WB_r;
      OP_JAL:  wb_data = {link_pc_s, 2'b00};
      default: wb_data = ALUOut_MEM_WB_r;
    endcase
  end

  // Read ports
  always_comb begin
    rdata1 = read_sel(raddr1, wb_we, wb_addr, wb_data, regs_r[raddr1]);
    rdata2 = read_sel(raddr2, wb_we, wb_addr, wb_data, regs_r[raddr2]);
  end

  // Register array; wb_we is already low for $0 and during reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (wb_we) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // Retirement tracking, counts every non-bubble including non-writers
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_cnt_r <= 32'h0000_0000;
      last_pc_r    <= 30'h0000_0000;
    end else if (!bubble_s) begin
      retire_cnt_r <= retire_cnt_r + 32'd1;
      last_pc_r    <= MEM_WB_PC_r;
    end
  end

  assign retire_cnt = retire_cnt_r;
  assign last_pc    = last_pc_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a driver pushes expected cycle responses from a
// behavioural model into a queue, a monitor pops and compares them each cycle.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] instr, dmem, alu;
  logic [4:0]  dst, ra1, ra2;
  logic [29:0] pc;
  logic [31:0] rdata1, rdata2, wb_data, retire_cnt;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [29:0] last_pc;

  wb_regfile dut (
    .clk(clk), .rst(rst), .MEM_WB_instr(instr), .DataMem_MEM_WB_r(dmem),
    .ALUOut_MEM_WB_r(alu), .WriteDst_MEM_WB_r(dst), .MEM_WB_PC_r(pc),
    .raddr1(ra1), .raddr2(ra2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .retire_cnt(retire_cnt), .last_pc(last_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] cnt;
    logic [29:0] lpc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  logic [29:0] m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: samples just before each rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check("wb_we", {31'd0, wb_we}, {31'd0, e.we});
          check("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
          check("wb_data", wb_data, e.data);
          check("rdata1", rdata1, e.r1);
          check("rdata2", rdata2, e.r2);
          check("retire_cnt", retire_cnt, e.cnt);
          check("last_pc", {2'd0, last_pc}, {2'd0, e.lpc});
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic in_write_set(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h00) return ins[5:0] != 6'h08;
    return (op >= 6'h08 && op <= 6'h0F) || op == 6'h23 || op == 6'h03;
  endfunction

  // Drive one cycle (called at a falling edge), record expectation, advance the model.
  task automatic drive(input logic [31:0] i_instr, input logic [31:0] i_dm, input logic [31:0] i_alu,
                       input logic [4:0] i_dst, input logic [29:0] i_pc,
                       input logic [4:0] i_ra1, input logic [4:0] i_ra2,
                       input logic i_rst, input logic i_chk);
    exp_t e;
    logic [29:0] npc;
    instr = i_instr; dmem = i_dm; alu = i_alu; dst = i_dst; pc = i_pc;
    ra1 = i_ra1; ra2 = i_ra2; rst = i_rst;
    npc = i_pc + 30'd1;
    e.chk  = i_chk;
    e.we   = i_rst && (i_instr != 32'd0) && in_write_set(i_instr) && (i_dst != 5'd0);
    e.addr = i_dst;
    if (i_instr[31:26] == 6'h23)      e.data = i_dm;
    else if (i_instr[31:26] == 6'h03) e.data = {npc, 2'b00};
    else                              e.data = i_alu;
    e.r1  = (i_ra1 == 5'd0) ? 32'd0 : (e.we && i_ra1 == i_dst) ? e.data : m_regs[i_ra1];
    e.r2  = (i_ra2 == 5'd0) ? 32'd0 : (e.we && i_ra2 == i_dst) ? e.data : m_regs[i_ra2];
    e.cnt = m_cnt;
    e.lpc = m_pc;
    exp_q.push_back(e);
    if (!i_rst) begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
      m_cnt = 32'd0;
      m_pc  = 30'd0;
    end else begin
      if (e.we) m_regs[i_dst] = e.data;
      if (i_instr != 32'd0) begin
        m_cnt = m_cnt + 32'd1;
        m_pc  = i_pc;
      end
    end
    @(negedge clk);
  endtask

  logic [5:0] op_tab [14];
  logic [31:0] r_ins;
  logic [4:0]  r_dst;

  initial begin
    for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    m_cnt = 32'd0;
    m_pc  = 30'd0;
    op_tab = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
               6'h23, 6'h03, 6'h2B, 6'h04, 6'h02};
    @(negedge clk);
    // Reset held two cycles with addi to $5; first cycle's pre-reset state is unknown
    drive(mk(6'h08, 6'h00), 32'h0, 32'h0000_0077, 5'd5, 30'h10, 5'd5, 5'd0, 1'b0, 1'b0);
    drive(mk(6'h08, 6'h00), 32'h0, 32'h0000_0077, 5'd5, 30'h10, 5'd5, 5'd5, 1'b0, 1'b1);
    // ALU write with same-cycle bypass, then array read
    drive(mk(6'h08, 6'h00), 32'h0, 32'hDEAD_BEEF, 5'd8, 30'h20, 5'd8, 5'd8, 1'b1, 1'b1);
    drive(32'h0, 32'h0, 32'h0, 5'd0, 30'h21, 5'd8, 5'd5, 1'b1, 1'b1);
    // Load vs ALU select
    drive(mk(6'h23, 6'h00), 32'h0000_1234, 32'h0000_9999, 5'd9, 30'h22, 5'd9, 5'd8, 1'b1, 1'b1);
    drive(mk(6'h0D, 6'h00), 32'h0000_1234, 32'h0000_0055, 5'd9, 30'h23, 5'd9, 5'd9, 1'b1, 1'b1);
    // jal link, including PC wrap
    drive(mk(6'h03, 6'h00), 32'h0, 32'h0, 5'd31, 30'h100, 5'd31, 5'd9, 1'b1, 1'b1);
    drive(32'h0, 32'h0, 32'h0, 5'd0, 30'h0, 5'd31, 5'd9, 1'b1, 1'b1);
    drive(mk(6'h03, 6'h00), 32'h0, 32'h0, 5'd31, 30'h3FFF_FFFF, 5'd31, 5'd0, 1'b1, 1'b1);
    // Non-writers and $0
    drive(mk(6'h2B, 6'h00), 32'h1, 32'h1, 5'd8, 30'h40, 5'd8, 5'd31, 1'b1, 1'b1);
    drive(mk(6'h04, 6'h00), 32'h2, 32'h2, 5'd9, 30'h41, 5'd9, 5'd31, 1'b1, 1'b1);
    drive({6'h00, 5'd31, 15'd0, 6'h08}, 32'h3, 32'h3, 5'd8, 30'h42, 5'd8, 5'd9, 1'b1, 1'b1);
    drive(mk(6'h08, 6'h00), 32'h0, 32'h0000_0007, 5'd0, 30'h43, 5'd0, 5'd0, 1'b1, 1'b1);
    drive(32'h0, 32'h0, 32'h0, 5'd0, 30'h55, 5'd0, 5'd8, 1'b1, 1'b1);
    // Counter wrap from a preloaded count
    force dut.retire_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_r;
    m_cnt = 32'hFFFF_FFFF;
    drive(mk(6'h2B, 6'h00), 32'h0, 32'h0, 5'd1, 30'h77, 5'd1, 5'd2, 1'b1, 1'b1);
    drive(32'h0, 32'h0, 32'h0, 5'd0, 30'h99, 5'd1, 5'd2, 1'b1, 1'b1);
    drive(32'h0, 32'h0, 32'h0, 5'd0, 30'h9A, 5'd1, 5'd2, 1'b1, 1'b1);
    // Randomised traffic with occasional mid-stream resets
    for (int n = 0; n < 400; n++) begin
      r_ins = {op_tab[$urandom_range(0, 13)], 26'($urandom)};
      if ($urandom_range(0, 9) == 0) r_ins = {6'($urandom), 26'($urandom)};
      if ($urandom_range(0, 7) == 0) r_ins[5:0] = 6'h08;
      if ($urandom_range(0, 7) == 0) r_ins = 32'h0;
      r_dst = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      drive(r_ins, $urandom, $urandom, r_dst, 30'($urandom),
            ($urandom_range(0, 2) == 0) ? r_dst : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? r_dst : 5'($urandom),
            ($urandom_range(0, 39) != 0), 1'b1);
    end
    for (int w = 0; w < 100 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
